// File: rtl/cmsdk_ahb_pkg.sv
// Shared AHB encodings and burst-length constants for the bus-matrix arbiters.
// Pure definitions: no logic, no latency, no flow control.
package cmsdk_ahb_pkg;

  localparam logic [1:0] TRN_IDLE   = 2'b00;
  localparam logic [1:0] TRN_BUSY   = 2'b01;
  localparam logic [1:0] TRN_NONSEQ = 2'b10;
  localparam logic [1:0] TRN_SEQ    = 2'b11;

  localparam logic [2:0] BUR_SINGLE = 3'b000;
  localparam logic [2:0] BUR_INCR   = 3'b001;
  localparam logic [2:0] BUR_WRAP4  = 3'b010;
  localparam logic [2:0] BUR_INCR4  = 3'b011;
  localparam logic [2:0] BUR_WRAP8  = 3'b100;
  localparam logic [2:0] BUR_INCR8  = 3'b101;
  localparam logic [2:0] BUR_WRAP16 = 3'b110;
  localparam logic [2:0] BUR_INCR16 = 3'b111;

  // Beats still to follow after the first two of a fixed burst.
  localparam logic [3:0] REM_X16 = 4'd14;
  localparam logic [3:0] REM_X8  = 4'd6;
  localparam logic [3:0] REM_X4  = 4'd2;

endpackage

// File: rtl/cmsdk_ahb_burst_tracker.sv
// Tracks the burst in flight on an output port; next_hold is combinational from the current beat.
// State advances only when en (HREADYM) is high; with en low everything holds.
module cmsdk_ahb_burst_tracker (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic       hsel,
  input  logic [1:0] htrans,
  input  logic [2:0] hburst,
  output logic       next_hold
);
  import cmsdk_ahb_pkg::*;

  logic [3:0] burst_remain;
  logic       burst_hold;
  logic [1:0] early_incr;
  logic [3:0] next_remain;
  logic [1:0] early_bump;
  logic [1:0] next_early;

  always_comb begin
    next_remain = burst_remain;
    next_hold   = burst_hold;
    early_bump  = early_incr;
    if (hsel && htrans == TRN_NONSEQ && burst_hold && early_incr != 2'd3)
      early_bump = early_incr + 2'd1;
    if (!hsel || htrans == TRN_IDLE) begin
      next_remain = '0;
      next_hold   = 1'b0;
    end else begin
      case (htrans)
        TRN_NONSEQ: begin
          case (hburst)
            BUR_INCR16, BUR_WRAP16: begin next_remain = REM_X16; next_hold = 1'b1; end
            BUR_INCR8,  BUR_WRAP8:  begin next_remain = REM_X8;  next_hold = 1'b1; end
            BUR_INCR4,  BUR_WRAP4:  begin next_remain = REM_X4;  next_hold = 1'b1; end
            // A new INCR that cut into a held sequence is not protected itself.
            BUR_INCR: begin next_remain = REM_X4; next_hold = (early_bump == 2'd0); end
            default:  begin next_remain = '0;     next_hold = 1'b0; end
          endcase
        end
        TRN_SEQ: begin
          if (burst_remain == '0) next_hold = 1'b0;
          else next_remain = burst_remain - 4'd1;
        end
        default: ;
      endcase
    end
    next_early = next_hold ? early_bump : 2'd0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      burst_remain <= '0;
      burst_hold   <= 1'b0;
      early_incr   <= '0;
    end else if (en) begin
      burst_remain <= next_remain;
      burst_hold   <= next_hold;
      early_incr   <= next_early;
    end
  end

endmodule

// File: rtl/cmsdk_ahb_wrr_arbiter.sv
// Weighted round-robin output-port arbiter: grant registered one HREADYM edge after request.
// All state stalls while HREADYM is low; bursts and locked sequences are never split.
module cmsdk_ahb_wrr_arbiter #(
  parameter int NUM_PORTS = 4,
  parameter int PORT_W    = 2,
  parameter int CREDIT_W  = 4
) (
  input  logic                          HCLK,
  input  logic                          HRESET,
  input  logic [NUM_PORTS-1:0]          req_port,
  input  logic [NUM_PORTS*CREDIT_W-1:0] weight_cfg,
  input  logic                          HREADYM,
  input  logic                          HSELM,
  input  logic [1:0]                    HTRANSM,
  input  logic [2:0]                    HBURSTM,
  input  logic                          HMASTLOCKM,
  output logic [PORT_W-1:0]             addr_in_port,
  output logic                          no_port,
  output logic [CREDIT_W-1:0]           credit_remain
);
  import cmsdk_ahb_pkg::*;

  // Returns {found, index}; searches cur+1 .. cur, skipping indices >= NUM_PORTS.
  function automatic logic [PORT_W:0] rot_search(input logic [NUM_PORTS-1:0] req,
                                                  input logic [PORT_W-1:0]    cur);
    logic [PORT_W:0] res;
    int              idx;
    res = '0;
    for (int k = NUM_PORTS; k >= 1; k--) begin
      idx = (int'(cur) + k) % NUM_PORTS;
      if (req[PORT_W'(idx)]) res = {1'b1, PORT_W'(idx)};
    end
    return res;
  endfunction

  function automatic logic [PORT_W:0] lowest_req(input logic [NUM_PORTS-1:0] req);
    logic [PORT_W:0] res;
    res = '0;
    for (int k = NUM_PORTS - 1; k >= 0; k--)
      if (req[PORT_W'(k)]) res = {1'b1, PORT_W'(k)};
    return res;
  endfunction

  function automatic logic [CREDIT_W-1:0] weight_of(input logic [NUM_PORTS*CREDIT_W-1:0] cfg,
                                                    input logic [PORT_W-1:0]             p);
    logic [CREDIT_W-1:0] w;
    w = cfg[p*CREDIT_W +: CREDIT_W];
    return (w == '0) ? CREDIT_W'(1) : w;
  endfunction

  logic                next_hold;
  logic                beat;
  logic                exhausted;
  logic                arb_point;
  logic                found_rot;
  logic                found_low;
  logic [PORT_W-1:0]   rot_idx;
  logic [PORT_W-1:0]   low_idx;
  logic [PORT_W-1:0]   nxt_port;
  logic                nxt_no_port;
  logic                reload;
  logic [CREDIT_W-1:0] nxt_credit;

  cmsdk_ahb_burst_tracker u_burst_tracker (
    .clk       (HCLK),
    .reset     (HRESET),
    .en        (HREADYM),
    .hsel      (HSELM),
    .htrans    (HTRANSM),
    .hburst    (HBURSTM),
    .next_hold (next_hold)
  );

  always_comb begin
    beat      = HREADYM & HSELM & (HTRANSM == TRN_NONSEQ || HTRANSM == TRN_SEQ) & ~no_port;
    exhausted = (credit_remain == '0) || (beat && credit_remain == CREDIT_W'(1));
    arb_point = ~HMASTLOCKM & ~next_hold;
    {found_rot, rot_idx} = rot_search(req_port, addr_in_port);
    {found_low, low_idx} = lowest_req(req_port);

    nxt_port    = addr_in_port;
    nxt_no_port = no_port;
    reload      = 1'b0;
    if (arb_point) begin
      if (no_port) begin
        if (found_low) begin
          nxt_port    = low_idx;
          nxt_no_port = 1'b0;
          reload      = 1'b1;
        end
      end else if (exhausted || !HSELM) begin
        if (found_rot) begin
          nxt_port = rot_idx;
          reload   = (rot_idx != addr_in_port) || exhausted;
        end else if (HSELM) begin
          reload = 1'b1;
        end else begin
          nxt_no_port = 1'b1;
        end
      end
    end

    // A reload wins over a decrement on the same edge.
    if (reload)
      nxt_credit = weight_of(weight_cfg, nxt_port);
    else if (beat && credit_remain != '0)
      nxt_credit = credit_remain - CREDIT_W'(1);
    else
      nxt_credit = credit_remain;
  end

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      addr_in_port  <= '0;
      no_port       <= 1'b1;
      credit_remain <= '0;
    end else if (HREADYM) begin
      addr_in_port  <= nxt_port;
      no_port       <= nxt_no_port;
      credit_remain <= nxt_credit;
    end
  end

endmodule

// File: tb/tb_cmsdk_ahb_wrr_arbiter.sv
// Directed bench for the weighted round-robin arbiter; expected grants are queued with each
// stimulus step and checked with immediate assertions one edge later.
module tb_cmsdk_ahb_wrr_arbiter;
  import cmsdk_ahb_pkg::*;

  localparam int NP = 4;
  localparam int PW = 2;
  localparam int CW = 4;

  logic              HCLK = 1'b0;
  logic              HRESET;
  logic [NP-1:0]     req_port;
  logic [NP*CW-1:0]  weight_cfg;
  logic              HREADYM;
  logic              HSELM;
  logic [1:0]        HTRANSM;
  logic [2:0]        HBURSTM;
  logic              HMASTLOCKM;
  logic [PW-1:0]     addr_in_port;
  logic              no_port;
  logic [CW-1:0]     credit_remain;

  cmsdk_ahb_wrr_arbiter #(.NUM_PORTS(NP), .PORT_W(PW), .CREDIT_W(CW)) dut (
    .HCLK          (HCLK),
    .HRESET        (HRESET),
    .req_port      (req_port),
    .weight_cfg    (weight_cfg),
    .HREADYM       (HREADYM),
    .HSELM         (HSELM),
    .HTRANSM       (HTRANSM),
    .HBURSTM       (HBURSTM),
    .HMASTLOCKM    (HMASTLOCKM),
    .addr_in_port  (addr_in_port),
    .no_port       (no_port),
    .credit_remain (credit_remain)
  );

  always #5 HCLK = ~HCLK;

  typedef struct {
    string         tag;
    logic          np;
    logic [PW-1:0] port;
    logic [CW-1:0] cred;
    logic          chk_port;
    logic          chk_cred;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  task automatic drive(input logic rdy, input logic sel, input logic [1:0] trn,
                       input logic [2:0] bur, input logic lock, input logic [NP-1:0] req);
    HREADYM    = rdy;
    HSELM      = sel;
    HTRANSM    = trn;
    HBURSTM    = bur;
    HMASTLOCKM = lock;
    req_port   = req;
  endtask

  task automatic expect_grant(input string tag, input logic np, input logic [PW-1:0] port,
                              input logic [CW-1:0] cred, input logic chk_port, input logic chk_cred);
    exp_t e;
    e.tag = tag; e.np = np; e.port = port; e.cred = cred;
    e.chk_port = chk_port; e.chk_cred = chk_cred;
    sb.push_back(e);
  endtask

  task automatic tick;
    exp_t e;
    @(posedge HCLK);
    #1;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      n_checks++;
      assert (no_port === e.np) else begin
        n_fail++;
        $error("FAIL %s no_port: observed %b expected %b", e.tag, no_port, e.np);
      end
      if (e.chk_port) begin
        n_checks++;
        assert (addr_in_port === e.port) else begin
          n_fail++;
          $error("FAIL %s addr_in_port: observed %0d expected %0d", e.tag, addr_in_port, e.port);
        end
      end
      if (e.chk_cred) begin
        n_checks++;
        assert (credit_remain === e.cred) else begin
          n_fail++;
          $error("FAIL %s credit_remain: observed %0d expected %0d", e.tag, credit_remain, e.cred);
        end
      end
    end
  endtask

  task automatic step(input string tag, input logic np, input logic [PW-1:0] port,
                      input logic [CW-1:0] cred);
    expect_grant(tag, np, port, cred, 1'b1, 1'b1);
    tick();
  endtask

  task automatic do_reset(input string tag);
    HRESET = 1'b1;
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, '0);
    step(tag, 1'b1, 2'd0, 4'd0);
    HRESET = 1'b0;
  endtask

  int rot_port[10] = '{0, 0, 1, 2, 3, 0, 0, 1, 1, 1};
  int rot_cred[10] = '{2, 1, 1, 1, 1, 2, 1, 1, 1, 1};

  initial begin
    // Reset with a single requester on port 1.
    weight_cfg = {4'd1, 4'd1, 4'd3, 4'd1};
    HRESET = 1'b1;
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0010);
    step("rst_cycle0", 1'b1, 2'd0, 4'd0);
    step("rst_cycle1", 1'b1, 2'd0, 4'd0);
    HRESET = 1'b0;
    step("single_grant", 1'b0, 2'd1, 4'd3);

    // Weighted rotation with continuous SINGLE beats, plus a stall at an arbitration point.
    do_reset("rst_rot");
    weight_cfg = {4'd1, 4'd1, 4'd1, 4'd2};
    drive(1'b1, 1'b1, TRN_NONSEQ, BUR_SINGLE, 1'b0, 4'b1111);
    for (int i = 0; i < 10; i++) begin
      if (i == 8 || i == 9) HREADYM = 1'b0;
      else HREADYM = 1'b1;
      step($sformatf("rot_%0d", i), 1'b0, PW'(rot_port[i]), CW'(rot_cred[i]));
    end
    HREADYM = 1'b1;
    step("rot_after_stall", 1'b0, 2'd2, 4'd1);

    // INCR8 on port 0 (weight 1) must not be broken by port 1.
    do_reset("rst_burst");
    weight_cfg = {4'd1, 4'd1, 4'd1, 4'd1};
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0011);
    step("burst_grant0", 1'b0, 2'd0, 4'd1);
    drive(1'b1, 1'b1, TRN_NONSEQ, BUR_INCR8, 1'b0, 4'b0011);
    step("incr8_beat1", 1'b0, 2'd0, 4'd0);
    HTRANSM = TRN_SEQ;
    for (int b = 2; b <= 7; b++) step($sformatf("incr8_beat%0d", b), 1'b0, 2'd0, 4'd0);
    step("incr8_beat8", 1'b0, 2'd1, 4'd1);

    // Wait states in the middle of an INCR4.
    do_reset("rst_wait");
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0011);
    step("wait_grant0", 1'b0, 2'd0, 4'd1);
    drive(1'b1, 1'b1, TRN_NONSEQ, BUR_INCR4, 1'b0, 4'b0011);
    step("incr4_beat1", 1'b0, 2'd0, 4'd0);
    HTRANSM = TRN_SEQ;
    step("incr4_beat2", 1'b0, 2'd0, 4'd0);
    HREADYM = 1'b0;
    for (int w = 0; w < 3; w++) step($sformatf("incr4_wait%0d", w), 1'b0, 2'd0, 4'd0);
    HREADYM = 1'b1;
    step("incr4_beat3", 1'b0, 2'd0, 4'd0);
    step("incr4_beat4", 1'b0, 2'd1, 4'd1);

    // Locked sequence on port 2 whose weight field is 0.
    do_reset("rst_lock");
    weight_cfg = {4'd1, 4'd0, 4'd1, 4'd1};
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0100);
    step("lock_grant2", 1'b0, 2'd2, 4'd1);
    drive(1'b1, 1'b1, TRN_NONSEQ, BUR_SINGLE, 1'b1, 4'b1111);
    for (int l = 1; l <= 5; l++) step($sformatf("lock_beat%0d", l), 1'b0, 2'd2, 4'd0);
    HMASTLOCKM = 1'b0;
    step("unlock_rotate", 1'b0, 2'd3, 4'd1);

    // Reset in the middle of an INCR8 clears the burst tracker too.
    do_reset("rst_mid");
    weight_cfg = {4'd1, 4'd1, 4'd1, 4'd1};
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0011);
    step("mid_grant0", 1'b0, 2'd0, 4'd1);
    drive(1'b1, 1'b1, TRN_NONSEQ, BUR_INCR8, 1'b0, 4'b0011);
    step("mid_beat1", 1'b0, 2'd0, 4'd0);
    HTRANSM = TRN_SEQ;
    step("mid_beat2", 1'b0, 2'd0, 4'd0);
    HRESET = 1'b1;
    step("mid_reset", 1'b1, 2'd0, 4'd0);
    HRESET = 1'b0;
    step("mid_rearb", 1'b0, 2'd0, 4'd1);

    // Back-to-back short INCR: the second burst is not protected.
    do_reset("rst_incr");
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0011);
    step("incr_grant0", 1'b0, 2'd0, 4'd1);
    drive(1'b1, 1'b1, TRN_NONSEQ, BUR_INCR, 1'b0, 4'b0011);
    step("incr_beat1", 1'b0, 2'd0, 4'd0);
    HTRANSM = TRN_SEQ;
    step("incr_beat2", 1'b0, 2'd0, 4'd0);
    step("incr_beat3", 1'b0, 2'd0, 4'd0);
    HTRANSM = TRN_NONSEQ;
    step("incr2_beat1", 1'b0, 2'd1, 4'd1);
    drive(1'b1, 1'b0, TRN_IDLE, BUR_SINGLE, 1'b0, 4'b0000);
    expect_grant("idle_no_port", 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
    tick();
    expect_grant("idle_stay", 1'b1, 2'd0, 4'd0, 1'b0, 1'b0);
    tick();
    req_port = 4'b0100;
    step("idle_regrant", 1'b0, 2'd2, 4'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/cmsdk_ahb_wrr_arbiter.md
Name: cmsdk_ahb_wrr_arbiter

Overview:
Weighted round-robin output-stage arbiter for the AHB bus matrix. It decides which input port drives a shared slave (output) port. Per-port weights allow a configured number of accepted beats per tenure before rotation. Fixed-length bursts, INCR bursts and locked sequences are never broken mid-sequence. It replaces the plain round-robin arbiter on output ports that need bandwidth shaping.

Parameters:
NUM_PORTS, 4, number of requesting input ports (2..8)
PORT_W, 2, width of port index; must equal clog2(NUM_PORTS)
CREDIT_W, 4, width of each weight field and of the credit counter

Ports:
HCLK  in  1  AHB system clock
HRESET  in  1  synchronous active-high reset
req_port  in  NUM_PORTS  per-port request; bit i = port i wants this slave
weight_cfg  in  NUM_PORTS*CREDIT_W  port i weight in bits [i*CREDIT_W +: CREDIT_W]; value 0 treated as 1; static except at idle
HREADYM  in  1  transfer done on output port
HSELM  in  1  output slave select, driven by the currently granted port
HTRANSM  in  2  output transfer type
HBURSTM  in  3  output burst type
HMASTLOCKM  in  1  output locked transfer
addr_in_port  out  PORT_W  granted port index (registered)
no_port  out  1  no port granted (registered)
credit_remain  out  CREDIT_W  beats left in current tenure (registered; debug/verification)

Behaviour:
- Clock and reset: one clock, HCLK. Reset HRESET is synchronous, active-high. On reset: no_port=1, addr_in_port=0, credit_remain=0, burst_remain=0, burst_hold=0, early_incr=0.
- Update enable: all state updates only on HCLK edges where HREADYM=1. When HREADYM=0, all state holds.
- Burst tracker (combinational next-state):
  - HSELM=0 or IDLE: remain=0, hold=0.
  - NONSEQ: remain=14/6/2 and hold=1 for x16/x8/x4 bursts. INCR: remain=2, hold=1, unless early_incr==1, then hold=0. SINGLE: hold=0.
  - SEQ: decrement remain; hold=0 when remain already 0.
  - BUSY: hold state.
  - early_incr: clears when next hold=0; increments when a NONSEQ arrives while hold=1. Width 2 bits, saturating.
- Beat accept: beat = HREADYM & HSELM & HTRANSM[1] & ~no_port. On beat, credit_remain decrements, saturating at 0.
- Arbitration point: HMASTLOCKM=0 and next_hold=0. Outside an arbitration point, grant and no_port hold.
- Next grant at an arbitration point:
  - If no_port=1: lowest-index requesting port wins, else remain no_port.
  - If credit exhausted (credit_remain==0, or reaches 0 on this beat) or HSELM=0: search ports cur+1, cur+2, … cur wrapping modulo NUM_PORTS. First requesting port wins. If none and HSELM=1, keep cur. If none and HSELM=0, set no_port=1.
  - Otherwise (credit>0 and HSELM=1): keep cur.
- Credit reload: when the grant changes, or no_port goes 1→0, or cur is kept after exhaustion, load credit_remain = max(weight[new],1).
- Credit during holds: credit may reach 0 mid-burst or mid-lock. Rotation then waits for the next arbitration point; the counter stays at 0 until then.
- Simultaneous events: a reload takes priority over a decrement in the same cycle.
- Wrap-around: the search index wraps modulo NUM_PORTS. NUM_PORTS that is not a power of two must skip indices ≥ NUM_PORTS.
- Reset mid-burst: reset aborts the tenure; the next cycle is an arbitration from no_port.
- Latency: the grant becomes visible one HCLK edge (with HREADYM=1) after the request.

Decomposition:
- Shared package cmsdk_ahb_pkg holds the HTRANS/HBURST encodings (TRN_*, BUR_*) and the burst-length constants 14/6/2.
- Sub-module cmsdk_ahb_burst_tracker holds the burst_remain/burst_hold/early_incr logic. It is reused by the existing arbiters.
- The rotating priority search is a function inside the top module.

Test Plan:
- Reset and single requester: hold HRESET 2 cycles, then req_port=0010 with weight1=3 → no_port=1 during reset. One edge later: addr_in_port=1, no_port=0, credit_remain=3.
- Weighted rotation: weights {2,1,1,1}, req=1111, continuous SINGLE NONSEQ with HREADYM=1 → grant sequence 0,0,1,2,3,0,0,…
- Burst protection: port0 weight=1 issues INCR8; port1 requesting → port0 held for all 8 beats. Switch to port1 at the edge after the 8th beat. credit_remain reads 0 during beats 2–8.
- Wait states: HREADYM=0 for 3 cycles mid-INCR4 → addr_in_port, credit_remain and burst state unchanged. Completion occurs after 4 accepted beats.
- Lock and weight 0: HMASTLOCKM=1 on port2 (weight=0, treated as 1) for 5 beats with req=1111 → grant stays 2. At the first unlocked SINGLE, the grant moves to 3.
- Idle and back-to-back short INCR: a 3-beat INCR followed by a NONSEQ INCR from port0 with port1 requesting → the second burst is not held (early_incr). Grant moves to 1 after its first beat. Then all req=0 with HSELM=0 → no_port=1.
